nios2_mul_pipe: RTL

- Parametrised successor to the fixed 32-bit, three-partial-product Nios II multiply cell.
- Computes the full 2*DATA_W product from four HALF_W x HALF_W partial products, so it also returns the high word.
- Supports unsigned, signed and mixed-sign operands, with valid/ready handshakes and backpressure.
- Sits between the CPU E-stage operand muxes and the M/W result path; also usable as a standalone multiply engine.

---
 rtl/nios2_mul_pipe.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/nios2_mul_pipe.sv
// nios2_mul_pipe -- three-stage pipelined DATA_W x DATA_W multiplier.
//
// Returns either the low word (MUL) or the high word of the full 2*DATA_W
// product for unsigned (MULXUU), signed x unsigned (MULXSU) and signed x
// signed (MULXSS) operands. The product is built from four unsigned
// HALF_W x HALF_W partial products. Signed high words are recovered from
// the unsigned high word by subtracting the sign corrections.
//
// Optional build macro: NIOS2_MUL_ACC_EN adds an accumulator. It adds the
// in_acc and in_acc_clr ports.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   in_valid/in_ready   operation handshake (in_ready depends on out_ready)
//   in_op               00 MUL, 01 MULXUU, 10 MULXSU, 11 MULXSS
//   in_a, in_b, in_tag  operands and sideband tag
//   in_acc, in_acc_clr  (NIOS2_MUL_ACC_EN only) accumulate / clear controls
//   out_valid/out_ready result handshake (out_valid is a register)
//   out_result, out_tag selected result word and its tag
//   busy                any stage occupied
module nios2_mul_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int HALF_W = DATA_W / 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
`ifdef NIOS2_MUL_ACC_EN
  input  logic              in_acc,
  input  logic              in_acc_clr,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXUU = 2'b01;
  localparam logic [1:0] OP_MULXSU = 2'b10;

  // Stage valids: vld_q[1] = S1, vld_q[2] = S2, vld_q[3] = S3.
  logic [3:1] vld_q, vld_d;
  logic       en1, en2, en3;

  // S1 registers
  logic [1:0]        s1_op_q;
  logic [TAG_W-1:0]  s1_tag_q;
  logic [DATA_W-1:0] s1_a_q, s1_b_q;
  logic              s1_an_q, s1_bn_q;
  logic [DATA_W-1:0] s1_ll_q, s1_lh_q, s1_hl_q, s1_hh_q;

  // S2 registers
  logic [1:0]          s2_op_q;
  logic [TAG_W-1:0]    s2_tag_q;
  logic [DATA_W-1:0]   s2_a_q, s2_b_q;
  logic                s2_an_q, s2_bn_q;
  logic [2*DATA_W-1:0] s2_sum_q;

  // S3 registers drive the outputs directly
  logic [DATA_W-1:0] s3_res_q, s3_res_d;
  logic [TAG_W-1:0]  s3_tag_q;

  // Zero-extend halves so each product is evaluated at full DATA_W width.
  logic [DATA_W-1:0] a_lo_x, a_hi_x, b_lo_x, b_hi_x;
  assign a_lo_x = {{HALF_W{1'b0}}, in_a[HALF_W-1:0]};
  assign a_hi_x = {{HALF_W{1'b0}}, in_a[DATA_W-1:HALF_W]};
  assign b_lo_x = {{HALF_W{1'b0}}, in_b[HALF_W-1:0]};
  assign b_hi_x = {{HALF_W{1'b0}}, in_b[DATA_W-1:HALF_W]};

  // A stage may load when it is empty or its contents move on this edge.
  assign en3      = ~vld_q[3] | out_ready;
  assign en2      = ~vld_q[2] | en3;
  assign en1      = ~vld_q[1] | en2;
  assign in_ready = en1;

  assign out_valid  = vld_q[3];
  assign out_result = s3_res_q;
  assign out_tag    = s3_tag_q;
  assign busy       = |vld_q;

  // Full unsigned product with carries fully propagated.
  logic [2*DATA_W-1:0] sum_d;
  assign sum_d = {{DATA_W{1'b0}}, s1_ll_q}
               + {{HALF_W{1'b0}}, s1_lh_q, {HALF_W{1'b0}}}
               + {{HALF_W{1'b0}}, s1_hl_q, {HALF_W{1'b0}}}
               + {s1_hh_q, {DATA_W{1'b0}}};

  // Signed high word = unsigned high word minus the sign corrections.
  logic [DATA_W-1:0] hi_w, lo_w, corr_a, corr_b, sel_w;
  assign hi_w   = s2_sum_q[2*DATA_W-1:DATA_W];
  assign lo_w   = s2_sum_q[DATA_W-1:0];
  assign corr_a = s2_an_q ? s2_b_q : '0;
  assign corr_b = s2_bn_q ? s2_a_q : '0;

  always_comb begin
    sel_w = hi_w;
    case (s2_op_q)
      OP_MUL:    sel_w = lo_w;
      OP_MULXUU: sel_w = hi_w;
      OP_MULXSU: sel_w = hi_w - corr_a;
      default:   sel_w = hi_w - corr_a - corr_b;
    endcase
  end

`ifdef NIOS2_MUL_ACC_EN
  logic              s1_acc_q, s1_clr_q, s2_acc_q, s2_clr_q;
  logic [DATA_W-1:0] acc_q, acc_d;

  // The accumulator is updated as the op enters S3. Ops never leave S3
  // out of order and are only discarded by reset, which also clears the
  // accumulator. As a result, the next op always sees the value left by
  // its predecessor.
  always_comb begin
    s3_res_d = sel_w + ((s2_acc_q && !s2_clr_q) ? acc_q : '0);
    acc_d    = acc_q;
    if (en3 && vld_q[2]) begin
      if (s2_acc_q)      acc_d = s3_res_d;
      else if (s2_clr_q) acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
    if (en1 && in_valid) begin
      s1_acc_q <= in_acc;
      s1_clr_q <= in_acc_clr;
    end
    if (en2 && vld_q[1]) begin
      s2_acc_q <= s1_acc_q;
      s2_clr_q <= s1_clr_q;
    end
  end
`else
  assign s3_res_d = sel_w;
`endif

  always_comb begin
    vld_d    = vld_q;
    vld_d[1] = en1 ? in_valid : vld_q[1];
    vld_d[2] = en2 ? vld_q[1] : vld_q[2];
    vld_d[3] = en3 ? vld_q[2] : vld_q[3];
  end

  // Control and output registers (reset)
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q    <= '0;
      s3_res_q <= '0;
      s3_tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (en3 && vld_q[2]) begin
        s3_res_q <= s3_res_d;
        s3_tag_q <= s2_tag_q;
      end
    end
  end

  // Datapath registers (qualified by the stage valids, no reset needed)
  always_ff @(posedge clk) begin
    if (en1 && in_valid) begin
      s1_op_q  <= in_op;
      s1_tag_q <= in_tag;
      s1_a_q   <= in_a;
      s1_b_q   <= in_b;
      s1_an_q  <= in_a[DATA_W-1];
      s1_bn_q  <= in_b[DATA_W-1];
      s1_ll_q  <= a_lo_x * b_lo_x;
      s1_lh_q  <= a_lo_x * b_hi_x;
      s1_hl_q  <= a_hi_x * b_lo_x;
      s1_hh_q  <= a_hi_x * b_hi_x;
    end
    if (en2 && vld_q[1]) begin
      s2_op_q  <= s1_op_q;
      s2_tag_q <= s1_tag_q;
      s2_a_q   <= s1_a_q;
      s2_b_q   <= s1_b_q;
      s2_an_q  <= s1_an_q;
      s2_bn_q  <= s1_bn_q;
      s2_sum_q <= sum_d;
    end
  end

endmodule
